// File: rtl/modn_pkg.sv
// Shared definitions for the mod-N counter family: state encodings,
// default geometry and the load-value clamp.
package modn_pkg;

  localparam int unsigned MODN_DEFAULT_N     = 10;
  localparam int unsigned MODN_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } modn_state_t;

  // Limit a requested start value to the top of the count range (n-1).
  function automatic int unsigned modn_clamp(input int unsigned v, input int unsigned n);
    return (v > n - 1) ? n - 1 : v;
  endfunction

endpackage

// File: rtl/modn_down_counter.sv
// Programmable mod-N down counter / timer digit. Counts a loaded value
// down to 0, then halts or reloads N-1. tc is a combinational borrow for
// chaining digits; done is a registered one-cycle pulse after tc.
module modn_down_counter
  import modn_pkg::*;
#(
  parameter int unsigned N     = MODN_DEFAULT_N,
  parameter int unsigned WIDTH = MODN_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             done,
  output logic             busy
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(N - 1);

  modn_state_t state;

  // Borrow out: zero-latency so the next digit's en can be driven directly.
  assign tc = (state == S_RUN) && en && (out == '0);

  // State, count and registered status flags; priority rst > load > stop > en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      out   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        out   <= WIDTH'(modn_clamp(int'(load_val), N));
        state <= S_RUN;
        busy  <= 1'b1;
      end else begin
        case (state)
          S_RUN: begin
            if (stop) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else if (en) begin
              if (out != '0) begin
                out <= out - 1'b1;
              end else begin
                done <= 1'b1;
                if (auto_reload) begin
                  out <= TOP;
                end else begin
                  state <= S_HALT;
                  busy  <= 1'b0;
                end
              end
            end
          end
          default: begin
            // IDLE and HALT hold everything; only load leaves them.
          end
        endcase
      end
    end
  end

endmodule
